bcd_countdown_timer: RTL and testbench

Parametrised MM:SS countdown timer for the microwave controller. It is the successor of the fixed three-digit timer. It adds:
- keypad digit entry, shifted in from the right;
- a configurable number of BCD minute digits;
- a built-in seconds prescaler;
- start, pause, cancel and door-interlock control;
- a one-cycle done pulse.

It sits between the keypad decoder and the display/magnetron control logic.

---
 rtl/bcd_countdown_timer.sv | 171 +++++++++++++++++
 tb/tb_bcd_countdown_timer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_countdown_timer.sv
// MM:SS BCD countdown timer with keypad entry, seconds prescaler, pause/cancel
// and door interlock; done pulses for one cycle when the count reaches 0:00.
module bcd_countdown_timer #(
  parameter int unsigned MIN_DIGITS = 2,
  parameter int unsigned TICK_DIV   = 1000
) (
  input  logic                    clk,
  input  logic                    clear,
  input  logic                    digit_valid,
  input  logic [3:0]              digit,
  input  logic                    start,
  input  logic                    pause,
  input  logic                    cancel,
  input  logic                    door_closed,
  output logic [3:0]              sec_ones,
  output logic [3:0]              sec_tens,
  output logic [4*MIN_DIGITS-1:0] mins,
  output logic                    running,
  output logic                    paused,
  output logic                    zero,
  output logic                    done
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              sec_ones_q, sec_ones_d;
  logic [3:0]              sec_tens_q, sec_tens_d;
  logic [4*MIN_DIGITS-1:0] mins_q, mins_d;
  logic [PW-1:0]           presc_q, presc_d;
  logic                    running_q, running_d;
  logic                    paused_q, paused_d;
  logic                    done_q, done_d;

  logic                    tick;
  logic [3:0]              dec_ones, dec_tens;
  logic [4*MIN_DIGITS-1:0] dec_mins;
  logic                    dec_zero;

  assign zero = (sec_ones_q == 4'd0) && (sec_tens_q == 4'd0) && (mins_q == '0);
  assign tick = (state_q == RUN) && door_closed && (presc_q == PRESC_MAX);

  // One-second BCD decrement; entered seconds above 59 are counted down as-is.
  always_comb begin : dec_logic
    logic borrow;
    dec_ones = sec_ones_q;
    dec_tens = sec_tens_q;
    dec_mins = mins_q;
    borrow   = 1'b0;
    if (sec_ones_q != 4'd0) begin
      dec_ones = sec_ones_q - 4'd1;
    end else if (sec_tens_q != 4'd0) begin
      dec_ones = 4'd9;
      dec_tens = sec_tens_q - 4'd1;
    end else begin
      dec_ones = 4'd9;
      dec_tens = 4'd5;
      borrow   = 1'b1;
      for (int unsigned i = 0; i < MIN_DIGITS; i++) begin
        if (borrow) begin
          if (mins_q[4*i +: 4] == 4'd0) begin
            dec_mins[4*i +: 4] = 4'd9;
          end else begin
            dec_mins[4*i +: 4] = mins_q[4*i +: 4] - 4'd1;
            borrow             = 1'b0;
          end
        end
      end
    end
    dec_zero = (dec_ones == 4'd0) && (dec_tens == 4'd0) && (dec_mins == '0);
  end

  // A higher-priority strobe masks lower ones even when it has no effect itself.
  always_comb begin
    state_d    = state_q;
    sec_ones_d = sec_ones_q;
    sec_tens_d = sec_tens_q;
    mins_d     = mins_q;
    presc_d    = presc_q;
    done_d     = 1'b0;
    if (cancel) begin
      state_d    = IDLE;
      sec_ones_d = '0;
      sec_tens_d = '0;
      mins_d     = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!pause) begin
            if (start) begin
              if (door_closed) begin
                state_d = RUN;
                presc_d = '0;
                if (zero) sec_tens_d = 4'd3;
              end
            end else if (digit_valid && (digit <= 4'd9)) begin
              sec_ones_d = digit;
              sec_tens_d = sec_ones_q;
              mins_d[3:0] = sec_tens_q;
              for (int unsigned i = 1; i < MIN_DIGITS; i++) begin
                mins_d[4*i +: 4] = mins_q[4*(i-1) +: 4];
              end
            end
          end
        end
        RUN: begin
          if (pause || !door_closed) begin
            state_d = PAUSE;
          end else if (tick) begin
            presc_d    = '0;
            sec_ones_d = dec_ones;
            sec_tens_d = dec_tens;
            mins_d     = dec_mins;
            if (dec_zero) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        PAUSE: begin
          if (!pause && start && door_closed) begin
            state_d = RUN;
            presc_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    running_d = (state_d == RUN);
    paused_d  = (state_d == PAUSE);
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q    <= IDLE;
      sec_ones_q <= '0;
      sec_tens_q <= '0;
      mins_q     <= '0;
      presc_q    <= '0;
      running_q  <= 1'b0;
      paused_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sec_ones_q <= sec_ones_d;
      sec_tens_q <= sec_tens_d;
      mins_q     <= mins_d;
      presc_q    <= presc_d;
      running_q  <= running_d;
      paused_q   <= paused_d;
      done_q     <= done_d;
    end
  end

  assign sec_ones = sec_ones_q;
  assign sec_tens = sec_tens_q;
  assign mins     = mins_q;
  assign running  = running_q;
  assign paused   = paused_q;
  assign done     = done_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Scoreboard bench for bcd_countdown_timer: an integer minutes/seconds model
// predicts every cycle's outputs; a negedge monitor compares them.
module tb_bcd_countdown_timer;

  localparam int unsigned MIN_DIGITS = 2;
  localparam int unsigned TICK_DIV   = 4;
  localparam int          ENTRY_MOD  = 10000;

  logic                    clk = 1'b0;
  logic                    clear, digit_valid, start, pause, cancel, door_closed;
  logic [3:0]              digit;
  logic [3:0]              sec_ones, sec_tens;
  logic [4*MIN_DIGITS-1:0] mins;
  logic                    running, paused, zero, done;

  always #5 clk = ~clk;

  bcd_countdown_timer #(.MIN_DIGITS(MIN_DIGITS), .TICK_DIV(TICK_DIV)) dut (
    .clk(clk), .clear(clear), .digit_valid(digit_valid), .digit(digit),
    .start(start), .pause(pause), .cancel(cancel), .door_closed(door_closed),
    .sec_ones(sec_ones), .sec_tens(sec_tens), .mins(mins),
    .running(running), .paused(paused), .zero(zero), .done(done)
  );

  typedef struct packed {
    logic [3:0]              so;
    logic [3:0]              st;
    logic [4*MIN_DIGITS-1:0] mn;
    logic                    run;
    logic                    pau;
    logic                    zr;
    logic                    dn;
  } obs_t;

  obs_t exp_q[$];
  int   tag_q[$];
  int   checks = 0;
  int   fails  = 0;
  int   phase  = 0;

  // Reference model: time kept as plain integers, mode as a small code.
  int m_min, m_sec, m_mode, m_cnt;
  bit m_done;

  function automatic obs_t model_obs();
    obs_t o;
    int   t;
    o.so = 4'(m_sec % 10);
    o.st = 4'(m_sec / 10);
    t = m_min;
    for (int i = 0; i < MIN_DIGITS; i++) begin
      o.mn[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    o.run = (m_mode == 1);
    o.pau = (m_mode == 2);
    o.zr  = (m_min == 0) && (m_sec == 0);
    o.dn  = m_done;
    return o;
  endfunction

  function automatic void model_step(bit clr, bit can, bit pau, bit sta, bit dv,
                                     int dg, bit door);
    int num;
    m_done = 0;
    if (clr) begin
      m_min = 0; m_sec = 0; m_mode = 0; m_cnt = 0;
    end else if (can) begin
      m_min = 0; m_sec = 0; m_mode = 0;
    end else if (m_mode == 1 && pau) begin
      m_mode = 2;
    end else if (m_mode == 0) begin
      if (pau) begin
        m_mode = 0;
      end else if (sta) begin
        if (door) begin
          if (m_min == 0 && m_sec == 0) m_sec = 30;
          m_mode = 1;
          m_cnt  = 0;
        end
      end else if (dv && dg <= 9) begin
        num   = ((m_min * 100 + m_sec) * 10 + dg) % ENTRY_MOD;
        m_min = num / 100;
        m_sec = num % 100;
      end
    end else if (m_mode == 1) begin
      if (!door) begin
        m_mode = 2;
      end else if (m_cnt == TICK_DIV - 1) begin
        m_cnt = 0;
        if (m_sec > 0) m_sec = m_sec - 1;
        else begin
          m_sec = 59;
          m_min = m_min - 1;
        end
        if (m_min == 0 && m_sec == 0) begin
          m_mode = 0;
          m_done = 1;
        end
      end else begin
        m_cnt = m_cnt + 1;
      end
    end else begin
      if (!pau && sta && door) begin
        m_mode = 1;
        m_cnt  = 0;
      end
    end
  endfunction

  task automatic step(input bit clr, input bit can, input bit pau, input bit sta,
                      input bit dv, input int dg, input bit door);
    @(negedge clk);
    #1;
    clear       = clr;
    cancel      = can;
    pause       = pau;
    start       = sta;
    digit_valid = dv;
    digit       = 4'(dg);
    door_closed = door;
    model_step(clr, can, pau, sta, dv, dg, door);
    exp_q.push_back(model_obs());
    tag_q.push_back(phase);
  endtask

  task automatic idle(input int n, input bit door);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, door);
  endtask

  task automatic key(input int dg);
    step(0, 0, 0, 0, 1, dg, 1);
  endtask

  always @(negedge clk) begin
    obs_t e, a;
    int   tg;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      tg = tag_q.pop_front();
      a.so  = sec_ones;
      a.st  = sec_tens;
      a.mn  = mins;
      a.run = running;
      a.pau = paused;
      a.zr  = zero;
      a.dn  = done;
      checks++;
      if (a !== e) begin
        fails++;
        $display("FAIL phase%0d t=%0t: got mins=%h tens=%h ones=%h run=%b pau=%b zero=%b done=%b, required mins=%h tens=%h ones=%h run=%b pau=%b zero=%b done=%b",
                 tg, $time, a.mn, a.st, a.so, a.run, a.pau, a.zr, a.dn,
                 e.mn, e.st, e.so, e.run, e.pau, e.zr, e.dn);
      end
    end
  end

  initial begin
    clear = 0; cancel = 0; pause = 0; start = 0; digit_valid = 0; digit = '0;
    door_closed = 1;
    m_min = 0; m_sec = 0; m_mode = 0; m_cnt = 0; m_done = 0;

    phase = 0;
    step(1, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 1);
    idle(2, 1);

    phase = 1;
    key(1); key(2); key(3); key(4);
    key(5);
    key(12);
    idle(1, 1);

    phase = 2;
    step(0, 1, 0, 0, 0, 0, 1);
    key(1); key(0); key(0);
    step(0, 0, 0, 1, 0, 0, 1);
    idle(10, 1);

    phase = 3;
    step(1, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 1);
    idle(2, 1);

    phase = 4;
    key(9); key(0);
    step(0, 0, 0, 1, 0, 0, 1);
    idle(90 * TICK_DIV + 5, 1);

    phase = 5;
    key(4); key(6);
    step(0, 0, 0, 1, 0, 0, 1);
    idle(TICK_DIV, 1);
    idle(3, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    idle(2, 0);
    step(0, 0, 0, 1, 0, 0, 1);
    idle(6, 1);
    step(0, 1, 0, 0, 0, 0, 1);
    idle(2, 1);

    phase = 6;
    step(0, 0, 0, 1, 0, 0, 1);
    key(7);
    step(0, 0, 0, 1, 0, 0, 1);
    idle(2, 1);
    step(0, 0, 1, 1, 0, 0, 1);
    idle(3, 1);
    step(0, 0, 0, 1, 0, 0, 1);
    idle(3, 1);
    step(0, 1, 0, 0, 0, 0, 1);
    idle(1, 1);

    phase = 7;
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 99) == 0,
           $urandom_range(0, 39) == 0, $urandom_range(0, 14) == 0,
           $urandom_range(0, 3) == 0, int'($urandom_range(0, 15)),
           $urandom_range(0, 19) != 0);
    end
    idle(1, 1);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
